// File: rtl/cmd_sched.sv
// Command scheduler: round-robin arbitration of four requesters into a command
// FIFO, with a level-dependent gravity timer that injects DOWN at lowest priority.
module cmd_sched #(
  parameter int unsigned QSIZE      = 16,
  parameter int unsigned DOWN_TICK  = 50_000_000,
  parameter int unsigned LEVEL_STEP = 4_000_000,
  parameter int unsigned MIN_TICK   = 5_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req_valid,
  input  logic [15:0] req_cmd,
  output logic [3:0]  req_ready,
  input  logic [3:0]  level,
  input  logic        paused,
  input  logic        flush,
  output logic        cmd_valid,
  output logic [3:0]  cmd,
  input  logic        cmd_ready,
  output logic [4:0]  fifo_cnt
);

  localparam int unsigned AW       = (QSIZE > 1) ? $clog2(QSIZE) : 1;
  localparam logic [4:0]  QSIZE_C  = 5'(QSIZE);
  localparam logic [3:0]  CMD_DOWN = 4'd3;

  function automatic logic cmd_ok(input logic [3:0] c);
    return (c >= 4'd1) && (c <= 4'd8);
  endfunction

  logic          run_r;
  logic [1:0]    rr_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [4:0]    cnt_r;
  logic [3:0]    mem_r [QSIZE];
  logic [31:0]   grav_cnt_r;
  logic          grav_pend_r;

  logic          active_s;
  logic          pop_s;
  logic          space_s;
  logic          win_found_s;
  logic [1:0]    win_idx_s;
  logic [3:0]    win_cmd_s;
  logic          grant_s;
  logic          ext_push_s;
  logic          ext_down_s;
  logic          grav_push_s;
  logic          push_s;
  logic [3:0]    push_data_s;
  logic [63:0]   step_s;
  logic [63:0]   period_s;
  logic          fire_s;

  // run_r holds the first edge after reset release as an idle cycle
  assign active_s    = run_r & ~flush;
  assign pop_s       = active_s & (cnt_r != 5'd0) & cmd_ready;
  assign space_s     = (cnt_r < QSIZE_C) | pop_s;
  assign win_cmd_s   = req_cmd[{win_idx_s, 2'b00} +: 4];
  assign grant_s     = active_s & space_s & win_found_s;
  assign ext_push_s  = grant_s & cmd_ok(win_cmd_s);
  assign ext_down_s  = ext_push_s & (win_cmd_s == CMD_DOWN);
  assign grav_push_s = active_s & ~grant_s & grav_pend_r & space_s;
  assign push_s      = ext_push_s | grav_push_s;
  assign push_data_s = ext_push_s ? win_cmd_s : CMD_DOWN;
  assign req_ready   = grant_s ? (4'b0001 << win_idx_s) : 4'b0000;
  assign cmd_valid   = (cnt_r != 5'd0);
  assign cmd         = cmd_valid ? mem_r[rd_ptr_r] : 4'd0;
  assign fifo_cnt    = cnt_r;

  // Round-robin search from rr_ptr; the lowest offset is written last and wins
  always_comb begin
    logic [1:0] cand_v;
    win_found_s = 1'b0;
    win_idx_s   = 2'd0;
    cand_v      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand_v      = rr_ptr_r + 2'(i);
      win_idx_s   = req_valid[cand_v] ? cand_v : win_idx_s;
      win_found_s = win_found_s | req_valid[cand_v];
    end
  end

  // Gravity period with a floor; compared as count+1 >= P so P-1 never underflows
  always_comb begin
    step_s = 64'(level) * 64'(LEVEL_STEP);
    if (64'(DOWN_TICK) > (step_s + 64'(MIN_TICK))) begin
      period_s = 64'(DOWN_TICK) - step_s;
    end else begin
      period_s = 64'(MIN_TICK);
    end
    fire_s = active_s & ~paused & ((64'(grav_cnt_r) + 64'd1) >= period_s);
  end

  // Reset-release qualifier
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Round-robin pointer advances past the winner only on a grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r <= 2'd0;
    end else if (grant_s) begin
      rr_ptr_r <= win_idx_s + 2'd1;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= 5'd0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= 5'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 5'd1;
        2'b01:   cnt_r <= cnt_r - 5'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(QSIZE); i++) begin
        mem_r[i] <= 4'd0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Gravity timer; a pending DOWN never accumulates beyond one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grav_cnt_r  <= 32'd0;
      grav_pend_r <= 1'b0;
    end else if (flush || ext_down_s) begin
      grav_cnt_r  <= 32'd0;
      grav_pend_r <= 1'b0;
    end else if (fire_s) begin
      grav_cnt_r  <= 32'd0;
      grav_pend_r <= 1'b1;
    end else begin
      if (active_s && !paused) begin
        grav_cnt_r <= grav_cnt_r + 32'd1;
      end else begin
        grav_cnt_r <= grav_cnt_r;
      end
      grav_pend_r <= grav_pend_r & ~grav_push_s;
    end
  end

endmodule

// File: tb/tb_cmd_sched.sv
// Directed bench for cmd_sched with a small FIFO and short gravity periods.
module tb_cmd_sched;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [15:0] req_cmd;
  logic [3:0]  req_ready;
  logic [3:0]  level;
  logic        paused;
  logic        flush;
  logic        cmd_valid;
  logic [3:0]  cmd;
  logic        cmd_ready;
  logic [4:0]  fifo_cnt;

  int checks = 0;
  int errors = 0;

  cmd_sched #(
    .QSIZE(4), .DOWN_TICK(20), .LEVEL_STEP(4), .MIN_TICK(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .level(level), .paused(paused), .flush(flush),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .fifo_cnt(fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] drain_q [4];

  initial begin
    reset_n = 1'b0; req_valid = 4'b1111; req_cmd = 16'h7621;
    level = 4'd0; paused = 1'b1; flush = 1'b0; cmd_ready = 1'b0;
    step(); step();
    #1;
    chk("rst_ready", 8'(req_ready), 8'h00);
    chk("rst_valid", 8'(cmd_valid), 8'h00);
    chk("rst_cnt", 8'(fifo_cnt), 8'h00);
    chk("rst_cmd", 8'(cmd), 8'h00);
    step();
    reset_n = 1'b1;
    #1 chk("idle_edge_ready", 8'(req_ready), 8'h00);
    step();

    // All four requesting: grants rotate 0..3, then FIFO full blocks
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_fill_ready", 8'(req_ready), 8'(4'b0001 << i));
      chk("rr_fill_cnt", 8'(fifo_cnt), 8'(i));
      step();
    end
    #1;
    chk("full_ready", 8'(req_ready), 8'h00);
    chk("full_cnt", 8'(fifo_cnt), 8'h04);
    chk("full_head", 8'(cmd), 8'h01);
    step();

    // Full FIFO with pop: push and pop in the same cycle
    req_valid = 4'b0010; req_cmd = 16'h7651; cmd_ready = 1'b1;
    #1 chk("pushpop_ready", 8'(req_ready), 8'h02);
    step();
    req_valid = 4'b0000;
    drain_q[0] = 4'd2; drain_q[1] = 4'd6; drain_q[2] = 4'd7; drain_q[3] = 4'd5;
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", 8'(cmd), 8'(drain_q[i]));
      chk("drain_cnt", 8'(fifo_cnt), 8'(4 - i));
      step();
    end
    chk("empty_valid", 8'(cmd_valid), 8'h00);
    chk("empty_cmd", 8'(cmd), 8'h00);

    // Invalid and NONE commands are granted but dropped (rr_ptr is 2 here)
    cmd_ready = 1'b0; req_valid = 4'b0001; req_cmd = 16'h765F;
    #1 chk("inval_ready", 8'(req_ready), 8'h01);
    step();
    chk("inval_cnt", 8'(fifo_cnt), 8'h00);
    req_valid = 4'b0100; req_cmd = 16'h7051;
    #1 chk("none_ready", 8'(req_ready), 8'h04);
    step();
    chk("none_cnt", 8'(fifo_cnt), 8'h00);

    // rr_ptr is 3: requesters 0 and 1 alternate 0,1,0
    req_valid = 4'b0011; req_cmd = 16'h7621;
    #1 chk("rr_a", 8'(req_ready), 8'h01);
    step();
    chk("rr_b", 8'(req_ready), 8'h02);
    step();
    chk("rr_c", 8'(req_ready), 8'h01);
    step();
    chk("rr_cnt", 8'(fifo_cnt), 8'h03);
    chk("rr_head", 8'(cmd), 8'h01);

    // Flush: no grant or pop, FIFO cleared, rr_ptr kept at 1
    flush = 1'b1; cmd_ready = 1'b1;
    #1 chk("flush_ready", 8'(req_ready), 8'h00);
    step();
    chk("flush_cnt", 8'(fifo_cnt), 8'h00);
    chk("flush_valid", 8'(cmd_valid), 8'h00);
    flush = 1'b0; cmd_ready = 1'b0;
    #1 chk("flush_rr_kept", 8'(req_ready), 8'h02);
    req_valid = 4'b0000;
    step();

    // Gravity at level 0: DOWN every 20 cycles
    flush = 1'b1; level = 4'd0;
    step();
    flush = 1'b0; paused = 1'b0;
    repeat (20) step();
    chk("grav0_before", 8'(fifo_cnt), 8'h00);
    step();
    chk("grav0_first", 8'(fifo_cnt), 8'h01);
    chk("grav0_cmd", 8'(cmd), 8'h03);
    repeat (19) step();
    chk("grav0_hold", 8'(fifo_cnt), 8'h01);
    step();
    chk("grav0_second", 8'(fifo_cnt), 8'h02);

    // Level 5 and level 15 both clamp to the 6-cycle floor
    paused = 1'b1; flush = 1'b1; level = 4'd5;
    step();
    flush = 1'b0; paused = 1'b0;
    repeat (6) step();
    chk("grav5_before", 8'(fifo_cnt), 8'h00);
    step();
    chk("grav5_first", 8'(fifo_cnt), 8'h01);
    repeat (5) step();
    chk("grav5_hold", 8'(fifo_cnt), 8'h01);
    step();
    chk("grav5_second", 8'(fifo_cnt), 8'h02);

    paused = 1'b1; flush = 1'b1; level = 4'd15;
    step();
    flush = 1'b0; paused = 1'b0;
    repeat (6) step();
    chk("grav15_before", 8'(fifo_cnt), 8'h00);
    step();
    chk("grav15_first", 8'(fifo_cnt), 8'h01);

    // Level raised while count already exceeds the new limit
    paused = 1'b1; flush = 1'b1; level = 4'd0;
    step();
    flush = 1'b0; paused = 1'b0;
    repeat (11) step();
    level = 4'd5;
    step();
    chk("lvlchg_fire", 8'(fifo_cnt), 8'h00);
    step();
    chk("lvlchg_push", 8'(fifo_cnt), 8'h01);

    // Pending gravity waits behind a continuous external grant
    paused = 1'b1; flush = 1'b1; level = 4'd5;
    step();
    flush = 1'b0; paused = 1'b0; req_valid = 4'b0001; req_cmd = 16'h765F;
    #1 chk("block_ready", 8'(req_ready), 8'h01);
    repeat (13) step();
    chk("block_cnt", 8'(fifo_cnt), 8'h00);
    req_valid = 4'b0000;
    step();
    chk("block_release", 8'(fifo_cnt), 8'h01);
    chk("block_cmd", 8'(cmd), 8'h03);
    repeat (3) step();
    chk("block_single", 8'(fifo_cnt), 8'h01);

    // External DOWN restarts the gravity counter
    paused = 1'b1; flush = 1'b1; level = 4'd0;
    step();
    flush = 1'b0; paused = 1'b0;
    repeat (10) step();
    req_valid = 4'b0001; req_cmd = 16'h7623;
    #1 chk("extdown_ready", 8'(req_ready), 8'h01);
    step();
    req_valid = 4'b0000;
    chk("extdown_cnt", 8'(fifo_cnt), 8'h01);
    repeat (20) step();
    chk("extdown_hold", 8'(fifo_cnt), 8'h01);
    step();
    chk("extdown_grav", 8'(fifo_cnt), 8'h02);

    // Flush with three queued and a pending DOWN
    paused = 1'b1; flush = 1'b1; level = 4'd5;
    step();
    flush = 1'b0; paused = 1'b0;
    repeat (24) step();
    chk("sflush_pre", 8'(fifo_cnt), 8'h03);
    flush = 1'b1; paused = 1'b1; req_valid = 4'b0001; req_cmd = 16'h7621; cmd_ready = 1'b1;
    #1 chk("sflush_ready", 8'(req_ready), 8'h00);
    step();
    chk("sflush_cnt", 8'(fifo_cnt), 8'h00);
    chk("sflush_valid", 8'(cmd_valid), 8'h00);
    flush = 1'b0; req_valid = 4'b0000; cmd_ready = 1'b0;
    repeat (2) step();
    chk("sflush_pend_gone", 8'(fifo_cnt), 8'h00);

    // Asynchronous reset with three queued and a pending DOWN
    flush = 1'b1;
    step();
    flush = 1'b0; paused = 1'b0;
    repeat (24) step();
    chk("arst_pre", 8'(fifo_cnt), 8'h03);
    #2 reset_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("arst_cnt", 8'(fifo_cnt), 8'h00);
    chk("arst_valid", 8'(cmd_valid), 8'h00);
    chk("arst_cmd", 8'(cmd), 8'h00);
    chk("arst_ready", 8'(req_ready), 8'h00);
    paused = 1'b1; req_valid = 4'b0000;
    step(); step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("arst_pend_gone", 8'(fifo_cnt), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
